// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw active-low key and enable in, conditioned step/level flags out.
interface button_conditioner_if;
    logic butt_n;
    logic en;
    logic step;
    logic pressed;
    logic repeating;

    modport master (output butt_n, output en, input step, input pressed, input repeating);
    modport slave  (input butt_n, input en, output step, output pressed, output repeating);
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces one active-low key, emitting a step pulse on press and
// hold-to-repeat steps (first after HOLD_CYC, then every REPEAT_CYC) while held.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | key released and settled
//   PRESS_DB   | key seen down, waiting for it to stay down DEBOUNCE_CYC
//   HOLD       | press accepted, first step issued, timing the hold delay
//   REPEAT     | held past the hold delay, stepping every REPEAT_CYC
//   RELEASE_DB | key seen up, waiting for DEBOUNCE_CYC of quiet
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 12_500_000,
    parameter int CNTW         = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HOLD,
        REPEAT,
        RELEASE_DB
    } state_t;

    localparam logic [CNTW-1:0] DB_LAST   = CNTW'(DEBOUNCE_CYC - 1);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPEAT_CYC - 1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic            sync1;
    logic            sync2;
    logic            btn;
    logic            step_r;
    logic            pressed_r;
    logic            repeating_r;

    assign btn           = ~sync2;
    assign bus.step      = step_r;
    assign bus.pressed   = pressed_r;
    assign bus.repeating = repeating_r;

    // The synchroniser keeps running while disabled so en can rise onto a settled level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.butt_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            state       <= IDLE;
            cnt         <= '0;
            step_r      <= 1'b0;
            pressed_r   <= 1'b0;
            repeating_r <= 1'b0;
        end else begin
            step_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        step_r    <= 1'b1;
                        pressed_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                HOLD: begin
                    if (!btn) begin
                        state       <= RELEASE_DB;
                        cnt         <= '0;
                        pressed_r   <= 1'b0;
                        repeating_r <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        state       <= REPEAT;
                        cnt         <= '0;
                        step_r      <= 1'b1;
                        repeating_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                REPEAT: begin
                    // Release wins over a step due on the same edge.
                    if (!btn) begin
                        state       <= RELEASE_DB;
                        cnt         <= '0;
                        pressed_r   <= 1'b0;
                        repeating_r <= 1'b0;
                    end else if (cnt == REP_LAST) begin
                        cnt    <= '0;
                        step_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                RELEASE_DB: begin
                    if (btn) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    pressed_r   <= 1'b0;
                    repeating_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed key patterns checked every cycle against a run-length model
// of the conditioner (consecutive down/up counts, time since acceptance).
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst;
    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYC (D),
        .HOLD_CYC     (H),
        .REPEAT_CYC   (R),
        .CNTW         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: two-sample delay on the key, then counts of consecutive edges.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    int   m_mode = 0;     // 0 not accepted, 1 accepted and held, 2 waiting for quiet release
    int   m_run = 0;      // consecutive down samples while not accepted
    int   m_held = 0;     // edges since the press was accepted
    int   m_quiet = 0;    // up samples since release seen or last bounce
    logic e_step = 1'b0, e_pressed = 1'b0, e_repeating = 1'b0;

    int   n_step, n_press;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic down;
        e_step = 1'b0;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_mode = 0; m_run = 0; m_held = 0; m_quiet = 0;
        end else begin
            down = ~m_s2;
            m_s2 = m_s1;
            m_s1 = bus.butt_n;
            if (!bus.en) begin
                m_mode = 0; m_run = 0; m_held = 0;
            end else if (m_mode == 0) begin
                m_run = down ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_mode = 1; m_held = 0; m_run = 0; e_step = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (!down) begin
                    m_mode = 2; m_quiet = 0;
                end else begin
                    m_held++;
                    e_step = (m_held >= H) && ((m_held - H) % R == 0);
                end
            end else begin
                m_quiet = down ? 0 : m_quiet + 1;
                if (m_quiet == D) begin
                    m_mode = 0; m_run = 0;
                end
            end
        end
        e_pressed   = (m_mode == 1);
        e_repeating = (m_mode == 1) && (m_held >= H);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("step", bus.step, e_step);
        chk("pressed", bus.pressed, e_pressed);
        chk("repeating", bus.repeating, e_repeating);
        if (bus.step) n_step++;
        if (bus.pressed) n_press++;
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            bus.butt_n = lvl;
            tick();
        end
    endtask

    task automatic toggle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.butt_n = ~bus.butt_n;
            tick();
        end
    endtask

    // Returns the 1-based tick at which the first step appears, 0 if none within n ticks.
    task automatic first_step(input int n, output int at);
        at = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.step && at == 0) at = i;
        end
    endtask

    int at;

    initial begin
        rst = 1'b1;
        bus.butt_n = 1'b1;
        bus.en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, 4);

        // long hold: one press step plus two repeats
        n_step = 0;
        drive(1'b0, 24);
        drive(1'b1, 12);
        chk("hold_steps", n_step, 3);

        // short glitch is rejected
        n_step = 0; n_press = 0;
        drive(1'b0, 3);
        drive(1'b1, 12);
        chk("glitch_steps", n_step, 0);
        chk("glitch_pressed", n_press, 0);

        // bouncy release still gives exactly one step
        n_step = 0;
        drive(1'b0, 8);
        toggle(6);
        drive(1'b1, 12);
        chk("bounce_steps", n_step, 1);

        // continuous chatter never accepted
        n_step = 0; n_press = 0;
        toggle(50);
        drive(1'b1, 10);
        chk("chatter_steps", n_step, 0);
        chk("chatter_pressed", n_press, 0);

        // disable mid-repeat, re-enable with key still held
        drive(1'b0, 25);
        bus.en = 1'b0;
        tick();
        chk("en_off_pressed", bus.pressed, 0);
        bus.en = 1'b1;
        first_step(8, at);
        chk("en_restep_at", at, D + 1);
        drive(1'b1, 12);

        // one-edge reset mid-repeat, key held
        drive(1'b0, 25);
        rst = 1'b1;
        tick();
        chk("rst_repeating", bus.repeating, 0);
        rst = 1'b0;
        first_step(10, at);
        chk("rst_restep_at", at, 7);
        drive(1'b1, 12);

        // random mix of holds, chatter, disables and resets
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: drive(1'b0, $urandom_range(1, 40));
                4, 5:       drive(1'b1, $urandom_range(1, 15));
                6, 7:       toggle($urandom_range(1, 12));
                8: begin
                    bus.en = 1'b0;
                    drive(1'($urandom_range(0, 1)), $urandom_range(1, 4));
                    bus.en = 1'b1;
                end
                default: begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
